// File: rtl/hazard_pkg.sv
// Shared widths and types for the ID-stage hazard controller.
// Defaults here match the top-level parameter defaults.
package hazard_pkg;
    localparam int NREG_DEF       = 32;
    localparam int LOAD_LAT_DEF   = 2;
    localparam int DIV_CYCLES_DEF = 32;

    localparam int REG_IDX_W = $clog2(NREG_DEF);
    localparam int CNT_W     = $clog2(LOAD_LAT_DEF + 1);

    typedef logic [CNT_W-1:0] sb_cnt_t;

    typedef struct packed {
        logic PC_Wr;
        logic ID_Wr;
        logic EXE_Flush;
    } hz_ctrl_t;
endpackage

// File: rtl/multicycle_busy_counter.sv
// Down-counter that reports busy for CYCLES cycles after a load.
// Clear has priority over load; freeze holds the count.
module multicycle_busy_counter #(
    parameter int CYCLES = 32
) (
    input  logic clk,
    input  logic resetn,
    input  logic load,
    input  logic freeze,
    input  logic clear,
    output logic busy
);
    localparam int W = $clog2(CYCLES + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= W'(CYCLES);
        end else if (!freeze && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign busy = (cnt != '0);
endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard controller: per-GPR load/MFC0 countdown scoreboard plus
// divider HI/LO busy tracking, driving PC/ID enables and the EXE bubble.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG       = NREG_DEF,
    parameter int LOAD_LAT   = LOAD_LAT_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     ID_Valid,
    input  logic [$clog2(NREG)-1:0]  ID_rs,
    input  logic [$clog2(NREG)-1:0]  ID_rt,
    input  logic [1:0]               ID_rsrtRead,
    input  logic [$clog2(NREG)-1:0]  ID_WrReg,
    input  logic                     ID_IsLoad,
    input  logic                     ID_IsMFC0,
    input  logic                     ID_IsDiv,
    input  logic                     ID_UseHILO,
    input  logic                     MEM_Stall,
    input  logic                     Flush,
    output logic                     PC_Wr,
    output logic                     ID_Wr,
    output logic                     EXE_Flush,
    output logic                     HILO_Busy
);
    localparam int IDX_W  = $clog2(NREG);
    localparam int LCNT_W = $clog2(LOAD_LAT + 1);

    logic [LCNT_W-1:0] cnt [NREG];
    logic raw, hilo, stall, issue, late_wr;
    hz_ctrl_t ctrl;

    assign raw   = ID_Valid & ((ID_rsrtRead[1] & (cnt[ID_rs] != '0)) |
                               (ID_rsrtRead[0] & (cnt[ID_rt] != '0)));
    assign hilo  = ID_Valid & (ID_IsDiv | ID_UseHILO) & HILO_Busy;
    assign stall = raw | hilo;
    assign issue = ID_Valid & ~stall & ~MEM_Stall & ~Flush;
    assign late_wr = issue & (ID_IsLoad | ID_IsMFC0) & (ID_WrReg != '0);

    // A new late write overrides the decrement of the same entry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < NREG; r++) cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (r == 0 || Flush) begin
                    cnt[r] <= '0;
                end else if (MEM_Stall) begin
                    cnt[r] <= cnt[r];
                end else if (late_wr && ID_WrReg == IDX_W'(r)) begin
                    cnt[r] <= LCNT_W'(LOAD_LAT);
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - 1'b1;
                end
            end
        end
    end

    // The divider keeps running through memory stalls.
    multicycle_busy_counter #(.CYCLES(DIV_CYCLES)) u_div_busy (
        .clk    (clk),
        .resetn (resetn),
        .load   (issue & ID_IsDiv),
        .freeze (1'b0),
        .clear  (Flush),
        .busy   (HILO_Busy)
    );

    always_comb begin
        ctrl.PC_Wr     = 1'b1;
        ctrl.ID_Wr     = 1'b1;
        ctrl.EXE_Flush = 1'b0;
        if (Flush) begin
            ctrl.EXE_Flush = 1'b1;
        end else if (MEM_Stall) begin
            ctrl.PC_Wr = 1'b0;
            ctrl.ID_Wr = 1'b0;
        end else if (stall) begin
            ctrl.PC_Wr     = 1'b0;
            ctrl.ID_Wr     = 1'b0;
            ctrl.EXE_Flush = 1'b1;
        end
    end

    assign PC_Wr     = ctrl.PC_Wr;
    assign ID_Wr     = ctrl.ID_Wr;
    assign EXE_Flush = ctrl.EXE_Flush;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with default parameters
// (NREG=32, LOAD_LAT=2, DIV_CYCLES=32).
module tb_hazard_scoreboard;
    logic       clk = 1'b0;
    logic       resetn;
    logic       ID_Valid;
    logic [4:0] ID_rs, ID_rt, ID_WrReg;
    logic [1:0] ID_rsrtRead;
    logic       ID_IsLoad, ID_IsMFC0, ID_IsDiv, ID_UseHILO;
    logic       MEM_Stall, Flush;
    logic       PC_Wr, ID_Wr, EXE_Flush, HILO_Busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .resetn(resetn), .ID_Valid(ID_Valid), .ID_rs(ID_rs), .ID_rt(ID_rt),
        .ID_rsrtRead(ID_rsrtRead), .ID_WrReg(ID_WrReg), .ID_IsLoad(ID_IsLoad),
        .ID_IsMFC0(ID_IsMFC0), .ID_IsDiv(ID_IsDiv), .ID_UseHILO(ID_UseHILO),
        .MEM_Stall(MEM_Stall), .Flush(Flush), .PC_Wr(PC_Wr), .ID_Wr(ID_Wr),
        .EXE_Flush(EXE_Flush), .HILO_Busy(HILO_Busy)
    );

    // Present one ID-stage cycle at the falling edge; outputs settle 1 ns later.
    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [1:0] rd, input logic [4:0] wr, input logic ld,
                         input logic mf, input logic dv, input logic hl,
                         input logic ms, input logic fl);
        @(negedge clk);
        ID_Valid = v; ID_rs = rs; ID_rt = rt; ID_rsrtRead = rd; ID_WrReg = wr;
        ID_IsLoad = ld; ID_IsMFC0 = mf; ID_IsDiv = dv; ID_UseHILO = hl;
        MEM_Stall = ms; Flush = fl;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Hold the current instruction and count bubble cycles until it issues (bounded).
    task automatic count_stalls(output int n);
        n = 0;
        while (EXE_Flush && !PC_Wr && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        idle(1);
        checks++;
        if ({PC_Wr, ID_Wr, EXE_Flush, HILO_Busy} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 1100", {PC_Wr, ID_Wr, EXE_Flush, HILO_Busy});
        end
        @(negedge clk); resetn = 1'b1;
        drive(1, 5, 6, 2'b11, 7, 0, 0, 0, 1, 0, 0);
        checks++;
        if (PC_Wr !== 1'b1 || EXE_Flush !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_no_stall: PC_Wr=%b EXE_Flush=%b expected 1 0", PC_Wr, EXE_Flush);
        end
        idle(2);
    endtask

    task automatic test_load_use;
        int n;
        drive(1, 1, 0, 2'b10, 5, 1, 0, 0, 0, 0, 0);
        checks++;
        if (PC_Wr !== 1'b1) begin
            errors++; $display("FAIL lw_issue: PC_Wr=%b expected 1", PC_Wr);
        end
        drive(1, 5, 0, 2'b10, 6, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({PC_Wr, ID_Wr, EXE_Flush} !== 3'b001) begin
            errors++; $display("FAIL load_use_ctrl: got %b expected 001", {PC_Wr, ID_Wr, EXE_Flush});
        end
        count_stalls(n);
        checks++;
        if (n !== 2) begin
            errors++; $display("FAIL load_use_stalls: got %0d expected 2", n);
        end
        idle(3);
        drive(1, 0, 0, 2'b00, 9, 0, 1, 0, 0, 0, 0);
        drive(1, 2, 9, 2'b01, 3, 0, 0, 0, 0, 0, 0);
        count_stalls(n);
        checks++;
        if (n !== 2) begin
            errors++; $display("FAIL mfc0_rt_stalls: got %0d expected 2", n);
        end
        idle(3);
    endtask

    task automatic test_gap_and_r0;
        int n;
        drive(1, 1, 0, 2'b10, 5, 1, 0, 0, 0, 0, 0);
        drive(1, 2, 3, 2'b11, 4, 0, 0, 0, 0, 0, 0);
        drive(1, 5, 0, 2'b10, 6, 0, 0, 0, 0, 0, 0);
        count_stalls(n);
        checks++;
        if (n !== 1) begin
            errors++; $display("FAIL gap_stalls: got %0d expected 1", n);
        end
        idle(3);
        drive(1, 1, 0, 2'b10, 0, 1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 2'b11, 6, 0, 0, 0, 0, 0, 0);
        count_stalls(n);
        checks++;
        if (n !== 0) begin
            errors++; $display("FAIL r0_stalls: got %0d expected 0", n);
        end
        idle(3);
    endtask

    task automatic test_self_and_back_to_back;
        int n;
        drive(1, 5, 0, 2'b10, 5, 1, 0, 0, 0, 0, 0);
        checks++;
        if (PC_Wr !== 1'b1 || EXE_Flush !== 1'b0) begin
            errors++; $display("FAIL self_hazard: PC_Wr=%b EXE_Flush=%b expected 1 0", PC_Wr, EXE_Flush);
        end
        drive(1, 1, 0, 2'b10, 5, 1, 0, 0, 0, 0, 0);
        drive(1, 5, 0, 2'b10, 6, 0, 0, 0, 0, 0, 0);
        count_stalls(n);
        checks++;
        if (n !== 2) begin
            errors++; $display("FAIL back_to_back_reload: got %0d expected 2", n);
        end
        idle(3);
    endtask

    task automatic test_mem_stall;
        int n;
        int bad = 0;
        drive(1, 1, 0, 2'b10, 5, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 5, 0, 2'b10, 6, 0, 0, 0, 0, 1, 0);
            if ({PC_Wr, ID_Wr, EXE_Flush} !== 3'b000) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL mem_stall_freeze: %0d bad cycles expected 0", bad);
        end
        drive(1, 5, 0, 2'b10, 6, 0, 0, 0, 0, 0, 0);
        count_stalls(n);
        checks++;
        if (n !== 2) begin
            errors++; $display("FAIL mem_stall_hold: got %0d stalls expected 2", n);
        end
        idle(3);
    endtask

    task automatic test_divider;
        int n;
        drive(1, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0);
        checks++;
        if (PC_Wr !== 1'b1 || HILO_Busy !== 1'b0) begin
            errors++; $display("FAIL div_issue: PC_Wr=%b HILO_Busy=%b expected 1 0", PC_Wr, HILO_Busy);
        end
        drive(1, 0, 0, 2'b00, 3, 0, 0, 0, 1, 0, 0);
        checks++;
        if (HILO_Busy !== 1'b1 || EXE_Flush !== 1'b1) begin
            errors++; $display("FAIL hilo_busy: HILO_Busy=%b EXE_Flush=%b expected 1 1", HILO_Busy, EXE_Flush);
        end
        count_stalls(n);
        checks++;
        if (n !== 32) begin
            errors++; $display("FAIL div_stalls: got %0d expected 32", n);
        end
        checks++;
        if (HILO_Busy !== 1'b0) begin
            errors++; $display("FAIL div_done: HILO_Busy=%b expected 0", HILO_Busy);
        end
        idle(2);
    endtask

    task automatic test_flush;
        drive(1, 1, 0, 2'b10, 5, 1, 0, 0, 0, 0, 0);
        drive(1, 5, 0, 2'b10, 6, 0, 0, 0, 0, 0, 1);
        checks++;
        if ({PC_Wr, ID_Wr, EXE_Flush} !== 3'b111) begin
            errors++; $display("FAIL flush_ctrl: got %b expected 111", {PC_Wr, ID_Wr, EXE_Flush});
        end
        drive(1, 5, 0, 2'b10, 6, 0, 0, 0, 0, 0, 0);
        checks++;
        if (PC_Wr !== 1'b1 || EXE_Flush !== 1'b0) begin
            errors++; $display("FAIL flush_clears: PC_Wr=%b EXE_Flush=%b expected 1 0", PC_Wr, EXE_Flush);
        end
        idle(2);
    endtask

    task automatic test_async_reset;
        drive(1, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0);
        idle(21);
        drive(1, 1, 0, 2'b10, 7, 1, 0, 0, 0, 0, 0);
        drive(1, 7, 0, 2'b10, 8, 0, 0, 0, 1, 0, 0);
        checks++;
        if ({PC_Wr, EXE_Flush, HILO_Busy} !== 3'b011) begin
            errors++; $display("FAIL pre_reset_state: got %b expected 011", {PC_Wr, EXE_Flush, HILO_Busy});
        end
        resetn = 1'b0;
        #1;
        checks++;
        if ({PC_Wr, ID_Wr, EXE_Flush, HILO_Busy} !== 4'b1100) begin
            errors++;
            $display("FAIL async_reset: got %b expected 1100", {PC_Wr, ID_Wr, EXE_Flush, HILO_Busy});
        end
        #1;
        resetn = 1'b1;
        #1;
        checks++;
        if (PC_Wr !== 1'b1 || EXE_Flush !== 1'b0 || HILO_Busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_no_stall: PC_Wr=%b EXE_Flush=%b HILO_Busy=%b expected 1 0 0",
                     PC_Wr, EXE_Flush, HILO_Busy);
        end
        idle(2);
    endtask

    initial begin
        ID_Valid = 0; ID_rs = 0; ID_rt = 0; ID_rsrtRead = 0; ID_WrReg = 0;
        ID_IsLoad = 0; ID_IsMFC0 = 0; ID_IsDiv = 0; ID_UseHILO = 0;
        MEM_Stall = 0; Flush = 0; resetn = 0;
        test_reset;
        test_load_use;
        test_gap_and_r0;
        test_self_and_back_to_back;
        test_mem_stall;
        test_divider;
        test_flush;
        test_async_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
